// File: rtl/seg_cap_pkg.sv
// rtl/seg_cap_pkg.sv - shared types, constants and helpers for the 7-segment frame capture
package seg_cap_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_DOT,
    ST_CR,
    ST_LF
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Active-low g..a patterns, identical to the display driver's encode table
  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h78;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h18;

  // Digit code to printable character; the illegal-pattern code prints as '?'
  function automatic logic [7:0] digit_char(input logic [3:0] hex);
    return (hex == 4'hF) ? ASCII_QMARK : ASCII_ZERO + {4'h0, hex};
  endfunction

  // True when exactly one select line is driven low
  function automatic logic sel_one_hot_low(input logic [7:0] sel);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) n = n + {3'b000, ~sel[i]};
    return n == 4'd1;
  endfunction

endpackage

// File: rtl/seg_frame_capture_if.sv
// rtl/seg_frame_capture_if.sv - ASCII byte stream toward the UART transmit path
interface seg_frame_capture_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low segment pattern to {legal, dp, hex}
module seg7_decode
  import seg_cap_pkg::*;
(
  input  logic [7:0] seg,
  output logic       legal,
  output logic       dp,
  output logic [3:0] hex
);

  // Reverse lookup of the encode table; anything unknown is flagged and coded F
  always_comb begin
    legal = 1'b1;
    dp    = ~seg[7];
    case (seg[6:0])
      SEG_PAT_0: hex = 4'h0;
      SEG_PAT_1: hex = 4'h1;
      SEG_PAT_2: hex = 4'h2;
      SEG_PAT_3: hex = 4'h3;
      SEG_PAT_4: hex = 4'h4;
      SEG_PAT_5: hex = 4'h5;
      SEG_PAT_6: hex = 4'h6;
      SEG_PAT_7: hex = 4'h7;
      SEG_PAT_8: hex = 4'h8;
      SEG_PAT_9: hex = 4'h9;
      default: begin
        hex   = 4'hF;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_frame_capture.sv
// rtl/seg_frame_capture.sv - samples the multiplexed display bus and streams each full frame as ASCII
module seg_frame_capture
  import seg_cap_pkg::*;
#(
  parameter int unsigned SETTLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    seg_in,
  input  logic [7:0]                    sel_in,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
  output logic                          err_flag,
  seg_frame_capture_if.master           tx
);

  localparam int RF_W    = NUM_DIGITS * DIGIT_W;
  localparam int TOP_LSB = (NUM_DIGITS - 1) * DIGIT_W;
  // The counter restarts one cycle after the new pair lands in the second
  // stage, so the pair has already been held two cycles when it reads zero.
  localparam logic [7:0] CNT_FIRE = 8'(SETTLE - 2);

  logic [7:0]  seg_s1, seg_s2, sel_s1, sel_s2, seg_q, sel_q;
  logic [7:0]  stab_cnt;
  logic        sampled;
  logic [2:0]  sel_idx, idx, idx_n, idx_m1;
  logic        sel_ok, pair_change, wr_en, snap, accept;
  logic        dec_legal, dec_dp;
  logic [3:0]  dec_hex;
  logic [7:0]  wr_bits, mask;
  logic [RF_W-1:0] digits_q, shadow_q;
  logic        err_q;
  tx_state_t   state, state_n;
  logic [7:0]  tx_data_q, tx_data_n;
  logic        tx_valid_q, tx_valid_n;

  seg7_decode u_decode (.seg(seg_s2), .legal(dec_legal), .dp(dec_dp), .hex(dec_hex));

  // Which digit the (single) low select line addresses
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!sel_s2[i]) sel_idx = 3'(i);
  end

  assign sel_ok      = sel_one_hot_low(sel_s2);
  assign pair_change = {sel_s2, seg_s2} != {sel_q, seg_q};
  assign wr_en       = sel_ok && !pair_change && !sampled && (stab_cnt == CNT_FIRE);
  assign wr_bits     = wr_en ? (8'h01 << sel_idx) : 8'h00;
  assign snap        = (mask == 8'hFF) && (state == ST_IDLE);
  assign accept      = tx_valid_q && tx.tx_ready;
  assign idx_m1      = idx - 3'd1;

  // Two-flop synchronizers plus a copy of the last synchronized pair for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= 8'hFF; seg_s2 <= 8'hFF; seg_q <= 8'hFF;
      sel_s1 <= 8'hFF; sel_s2 <= 8'hFF; sel_q <= 8'hFF;
    end else begin
      seg_s1 <= seg_in; seg_s2 <= seg_s1; seg_q <= seg_s2;
      sel_s1 <= sel_in; sel_s2 <= sel_s1; sel_q <= sel_s2;
    end
  end

  // Saturating stability counter and the once-per-select-period write lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
      sampled  <= 1'b0;
    end else begin
      if (pair_change || !sel_ok) stab_cnt <= '0;
      else if (stab_cnt != 8'hFF) stab_cnt <= stab_cnt + 8'd1;
      if (sel_s2 != sel_q) sampled <= 1'b0;
      else if (wr_en)      sampled <= 1'b1;
    end
  end

  // Live register file, capture mask and frame snapshot; a write on the snapshot edge survives in the mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      shadow_q <= '0;
      mask     <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        digits_q[sel_idx*DIGIT_W +: DIGIT_W] <= {dec_dp, dec_hex};
        if (!dec_legal) err_q <= 1'b1;
      end
      if (snap) begin
        shadow_q <= digits_q;
        mask     <= wr_bits;
      end else begin
        mask <= mask | wr_bits;
      end
    end
  end

  // Transmit FSM state and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
    end
  end

  // Next byte of the line: digits 7..0 with optional dots, then CR LF
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    case (state)
      ST_IDLE: if (snap) begin
        state_n    = ST_DIGIT;
        idx_n      = 3'd7;
        tx_data_n  = digit_char(digits_q[TOP_LSB +: 4]);
        tx_valid_n = 1'b1;
      end
      ST_DIGIT: if (accept) begin
        if (shadow_q[idx*DIGIT_W + 4]) begin
          state_n   = ST_DOT;
          tx_data_n = ASCII_DOT;
        end else if (idx == 3'd0) begin
          state_n   = ST_CR;
          tx_data_n = ASCII_CR;
        end else begin
          idx_n     = idx_m1;
          tx_data_n = digit_char(shadow_q[idx_m1*DIGIT_W +: 4]);
        end
      end
      ST_DOT: if (accept) begin
        if (idx == 3'd0) begin
          state_n   = ST_CR;
          tx_data_n = ASCII_CR;
        end else begin
          state_n   = ST_DIGIT;
          idx_n     = idx_m1;
          tx_data_n = digit_char(shadow_q[idx_m1*DIGIT_W +: 4]);
        end
      end
      ST_CR: if (accept) begin
        state_n   = ST_LF;
        tx_data_n = ASCII_LF;
      end
      ST_LF: if (accept) begin
        state_n    = ST_IDLE;
        tx_valid_n = 1'b0;
      end
      default: begin
        state_n    = ST_IDLE;
        tx_valid_n = 1'b0;
      end
    endcase
  end

  assign digits_out  = digits_q;
  assign err_flag    = err_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: doc/seg_frame_capture.md
# seg_frame_capture

Display-side receiver for the stopwatch's multiplexed 8-digit 7-segment bus. It samples the active-low segment and digit-select lines, decodes each lit pattern back to its 5-bit digit code, and keeps a live 8-digit register file. Each complete frame is streamed as ASCII bytes over a valid/ready port into the UART transmit path, which gives remote readout and loopback self-checking of the display driver.

## Interface
- `SETTLE`, default 16: consecutive cycles the synchronized select/segment pair must hold constant before a digit is sampled; legal range 2..255.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `seg_in`  in  8  active-low segments; [6:0] = g..a, [7] = decimal point (0 = lit).
- `sel_in`  in  8  active-low digit select; exactly one bit low selects digit index 0..7.
- `digits_out`  out  40  live register file; digit i at [5i+4:5i] = {dp, hex[3:0]}.
- `err_flag`  out  1  sticky; set when a sampled pattern is not a legal digit.
- `tx_data`  out  8  ASCII byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  consumer accepts the byte when `tx_valid` and `tx_ready` are both high.

## Operation
- **Input synchronizer:** `seg_in` and `sel_in` each pass through a 2-flop synchronizer. All further logic uses the synchronized values.
- **Stability counter (8 bits, saturating):**
  - Resets to 0 on any change of the {sel, seg} pair, or whenever sel is not one-hot-low.
  - Otherwise increments.
  - When it reaches `SETTLE`, the digit at the selected index is written once. A per-period `sampled` flag blocks rewrites until sel changes.
- **Decode** (active-low 7-bit pattern → hex):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9.
  - Any other pattern → hex 4'hF and sets `err_flag`.
  - dp bit = !seg[7].
- **Capture mask:** an 8-bit mask sets bit i on each write of digit i.
- **Snapshot:** taken when mask == 8'hFF and the FSM is in IDLE.
  - The 40-bit register file is copied to a shadow register and the mask is cleared.
  - While the FSM is busy, digits keep updating and the mask stays full; the snapshot is taken on the first IDLE cycle, using the latest values.
- **FSM states:** IDLE, DIGIT, DOT, CR, LF. Index i counts 7 down to 0.
  - DIGIT sends "0"–"9" (0x30+hex), or "?" (0x3F) for hex F. On accept: go to DOT if dp(i); else go to CR if i == 0; else decrement i and stay in DIGIT.
  - DOT sends 0x2E. On accept: go to CR if i == 0; else decrement i and go to DIGIT.
  - CR sends 0x0D, then LF sends 0x0A, then return to IDLE.
- **Reset values:**
  - `digits_out` = 40'h0, `err_flag` = 0, `tx_valid` = 0, `tx_data` = 8'h00.
  - Mask = 0, counter = 0, FSM = IDLE.
  - Synchronizer flops reset to 8'hFF (all off, no select).
- Reset asserted mid-stream aborts the frame immediately. No partial line is resumed.

## Timing
- Pin change before edge e appears at the synchronizer output at edge e+1. The digit register updates at edge e+1+`SETTLE` if the pair stays constant.
- The mask bit sets on the same edge as its digit write.
- Snapshot edge (mask full, IDLE): `tx_valid` rises and `tx_data` = character for digit 7 on that same edge's outputs. There is no extra bubble.
- `tx_data` and `tx_valid` are registered outputs. They hold steady while `tx_valid` is high and `tx_ready` is low.
- Back-to-back accepts advance one byte per cycle. A full frame without dp bits is 10 bytes; maximum is 18.
- **Simultaneous events:** if a digit write coincides with the snapshot edge, the shadow copy takes the pre-write value. The mask then holds only that newly written bit (set wins over clear).
- `err_flag` clears only on `rst`.

## Structure
- Package `seg_cap_pkg` holds:
  - FSM state encoding.
  - ASCII constants (0x30, 0x2E, 0x3F, 0x0D, 0x0A).
  - The ten 7-bit segment pattern constants, shared with the display driver's encode table.
  - Digit-code width (5) and digit count (8).
- Sub-module `seg7_decode`: combinational, maps 8-bit `seg` to {legal, dp, hex[3:0]}.
- The top level holds the synchronizer, stability counter, register file, mask, shadow register and transmit FSM.

## Test plan
- **Full frame with one dp:** drive the display driver pattern for digits 7..0 = 8,7,6,5,4,3,2,1 with dp on digit 2, `SETTLE` = 16, dwell 64 cycles per digit, `tx_ready` = 1 → bytes 38 37 36 35 34 33 2E 32 31 0D 0A. `digits_out` = {5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h13, 5'h02, 5'h01} (digit 7 at the MSBs).
- **Short dwell:** hold each select for only `SETTLE`−1 cycles → no digit writes, `tx_valid` stays 0.
- **Illegal pattern:** seg = 8'hFF on digit 4 → digit 4 = 5'h0F, `err_flag` = 1, stream byte 3F at position 4 (digit 7 sent first).
- **Backpressure:** `tx_ready` low for 5 cycles on each byte → `tx_data` holds each value unchanged, with identical byte order and count.
- **Reset mid-stream:** assert `rst` after the 3rd accepted byte → `tx_valid` = 0 and all outputs are at reset values within the same cycle. After release, a fresh full frame is produced only after 8 new captures.
- **Non-one-hot select:** sel = 8'b1111_1100 for 100 cycles → no writes, counter held at 0.
